// File: rtl/aes_inv_round_ctrl_if.sv
// Block-side bus of the iterative AES decryptor: ciphertext in, round-key lookup, plaintext out.
// The slave modport is the decryptor; the master modport is the surrounding system.
interface aes_inv_round_ctrl_if;
    logic         i_in_valid;
    logic         o_in_ready;
    logic [127:0] i_ciphertext;
    logic [3:0]   o_key_idx;
    logic [127:0] i_round_key;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [127:0] o_plaintext;

    modport slave (
        input  i_in_valid, i_ciphertext, i_round_key, i_out_ready,
        output o_in_ready, o_key_idx, o_out_valid, o_plaintext
    );

    modport master (
        output i_in_valid, i_ciphertext, i_round_key, i_out_ready,
        input  o_in_ready, o_key_idx, o_out_valid, o_plaintext
    );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys fetched by index.
// Optional status outputs (o_busy, o_blk_count, o_round) are enabled with `define AES_INV_STATUS_EN.
module aes_inv_round_ctrl #(
    parameter int NR = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    aes_inv_round_ctrl_if.slave  bus
`ifdef AES_INV_STATUS_EN
    ,
    output logic                 o_busy,
    output logic [15:0]          o_blk_count,
    output logic [3:0]           o_round
`endif
);

    generate
        if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
            $error("aes_inv_round_ctrl: NR must be 10, 12 or 14");
        end
    endgenerate

    localparam logic [3:0] NR_L  = 4'(NR);
    localparam logic [3:0] NR_M1 = 4'(NR - 1);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); zero maps to zero as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] r;
        s = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        int           src;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            src = (i % 4) + 4 * (((i / 4) + 4 - (i % 4)) % 4);
            o[127 - 8*i -: 8] = s[127 - 8*src -: 8];
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127 - 32*c -: 32];
            o[127 - 32*c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return o;
    endfunction

    state_t       r_fsm;
    logic [3:0]   r_cnt;
    logic [127:0] r_state;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [3:0]   r_key_idx;

    logic [127:0] w_t;
    logic [127:0] w_imc;

    assign w_t   = inv_sub_bytes(inv_shift_rows(r_state)) ^ bus.i_round_key;
    assign w_imc = inv_mix_columns(w_t);

    // Outputs are registered alongside the next state so the key index never depends on inputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fsm       <= S_IDLE;
            r_cnt       <= 4'd0;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_key_idx   <= NR_L;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (bus.i_in_valid) begin
                        r_state    <= bus.i_ciphertext ^ bus.i_round_key;
                        r_cnt      <= NR_M1;
                        r_key_idx  <= NR_M1;
                        r_in_ready <= 1'b0;
                        r_fsm      <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (r_cnt != 4'd0) begin
                        r_state   <= w_imc;
                        r_cnt     <= r_cnt - 4'd1;
                        r_key_idx <= r_cnt - 4'd1;
                    end else begin
                        r_state     <= w_t;
                        r_key_idx   <= 4'd0;
                        r_out_valid <= 1'b1;
                        r_fsm       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_key_idx   <= NR_L;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_in_ready  = r_in_ready;
    assign bus.o_out_valid = r_out_valid;
    assign bus.o_key_idx   = r_key_idx;
    assign bus.o_plaintext = r_state;

`ifdef AES_INV_STATUS_EN
    logic [15:0] r_blk_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_blk_count <= 16'd0;
        end else if (r_out_valid && bus.i_out_ready) begin
            r_blk_count <= r_blk_count + 16'd1;
        end
    end

    assign o_busy      = (r_fsm != S_IDLE);
    assign o_blk_count = r_blk_count;
    assign o_round     = (r_fsm == S_ROUND) ? r_cnt : 4'd0;
`endif

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: FIPS-197 vectors plus random blocks checked against a forward-cipher model.
// Status checks are compiled in when AES_INV_STATUS_EN is defined.
module tb_aes_inv_round_ctrl;
    logic clk;
    logic rst;
    aes_inv_round_ctrl_if bus();

`ifdef AES_INV_STATUS_EN
    logic        busy;
    logic [15:0] blk_count;
    logic [3:0]  round;
`endif

    aes_inv_round_ctrl #(.NR(10)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
`ifdef AES_INV_STATUS_EN
        ,
        .o_busy      (busy),
        .o_blk_count (blk_count),
        .o_round     (round)
`endif
    );

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic [7:0]   sbox [256];
    logic [127:0] rk [16];
    int           n_chk  = 0;
    int           n_pass = 0;
    int           cyc    = 0;
    int           acc_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Key store: combinational lookup by the requested index.
    always_comb begin
        bus.i_round_key = rk[bus.o_key_idx];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.i_in_valid && bus.o_in_ready) acc_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Forward S-box built by brute-force inverse search followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic key_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = '0;
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] p);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = p[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127 - 8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, input int hold);
        int k;
        bus.i_ciphertext = ct;
        bus.i_in_valid   = 1'b1;
        bus.i_out_ready  = 1'b0;
        chk("in_ready_idle", bus.o_in_ready, 1);
        chk("kidx_idle", bus.o_key_idx, 10);
        @(posedge clk); #1;
        bus.i_in_valid   = 1'b0;
        bus.i_ciphertext = rand128();
        k = 0;
        while (!bus.o_out_valid && k < 40) begin
            chk("kidx_round", bus.o_key_idx, 128'(9 - k));
            chk("in_ready_round", bus.o_in_ready, 0);
`ifdef AES_INV_STATUS_EN
            chk("busy_round", busy, 1);
            chk("round_idx", round, 128'(9 - k));
`endif
            @(posedge clk); #1;
            k++;
        end
        chk("latency", k, 10);
        chk("kidx_done", bus.o_key_idx, 0);
`ifdef AES_INV_STATUS_EN
        chk("round_done", round, 0);
        chk("busy_done", busy, 1);
`endif
        for (int h = 0; h < hold; h++) begin
            chk("pt_hold", bus.o_plaintext, exp);
            chk("valid_hold", bus.o_out_valid, 1);
            chk("in_ready_hold", bus.o_in_ready, 0);
            bus.i_in_valid   = 1'($urandom_range(0, 1));
            bus.i_ciphertext = rand128();
            @(posedge clk); #1;
        end
        bus.i_in_valid  = 1'b0;
        bus.i_out_ready = 1'b1;
        chk("plaintext", bus.o_plaintext, exp);
        chk("valid_done", bus.o_out_valid, 1);
        @(posedge clk); #1;
        bus.i_out_ready = 1'b0;
        chk("valid_drop", bus.o_out_valid, 0);
        chk("in_ready_back", bus.o_in_ready, 1);
    endtask

    initial begin
        logic [127:0] p_rnd;
        logic [127:0] c_rnd;
        int           k;
        int           gap;

        rst              = 1'b1;
        bus.i_in_valid   = 1'b0;
        bus.i_out_ready  = 1'b0;
        bus.i_ciphertext = '0;
        for (int r = 0; r < 16; r++) rk[r] = '0;
        build_sbox();
        #12;
        chk("rst_out_valid", bus.o_out_valid, 0);
        chk("rst_in_ready", bus.o_in_ready, 1);
        chk("rst_plaintext", bus.o_plaintext, 0);
        chk("rst_key_idx", bus.o_key_idx, 10);
`ifdef AES_INV_STATUS_EN
        chk("rst_busy", busy, 0);
        chk("rst_blk_count", blk_count, 0);
        chk("rst_round", round, 0);
`endif
        #1 rst = 1'b0;
        @(posedge clk); #1;

        key_expand(KEY_C1);
        run_block(CT_C1, PT_C1, 0);
        key_expand(KEY_B);
        run_block(CT_B, PT_B, 0);
        key_expand(KEY_C1);
        run_block(CT_C1, PT_C1, 20);
`ifdef AES_INV_STATUS_EN
        chk("blk_count_3", blk_count, 3);
`endif

        // Back-to-back: two queued blocks with i_in_valid held high.
        p_rnd = rand128();
        c_rnd = encrypt(p_rnd);
        acc_q.delete();
        bus.i_ciphertext = CT_C1;
        bus.i_in_valid   = 1'b1;
        bus.i_out_ready  = 1'b1;
        @(posedge clk); #1;
        bus.i_ciphertext = c_rnd;
        k = 0;
        while (!bus.o_out_valid && k < 40) begin @(posedge clk); #1; k++; end
        chk("b2b_pt_a", bus.o_plaintext, PT_C1);
        @(posedge clk); #1;
        chk("b2b_in_ready", bus.o_in_ready, 1);
        k = 0;
        while (!bus.o_out_valid && k < 40) begin @(posedge clk); #1; k++; end
        chk("b2b_pt_b", bus.o_plaintext, p_rnd);
        bus.i_in_valid = 1'b0;
        @(posedge clk); #1;
        bus.i_out_ready = 1'b0;
        chk("b2b_accepts", acc_q.size(), 2);
        gap = (acc_q.size() >= 2) ? (acc_q[1] - acc_q[0]) : -1;
        chk("b2b_interval", gap, 12);

        // Asynchronous reset while the counter is at 4.
        bus.i_ciphertext = CT_C1;
        bus.i_in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.i_in_valid = 1'b0;
        k = 0;
        while (bus.o_key_idx != 4'd4 && k < 40) begin @(posedge clk); #1; k++; end
        chk("mid_kidx", bus.o_key_idx, 4);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.o_out_valid, 0);
        chk("mid_rst_in_ready", bus.o_in_ready, 1);
        chk("mid_rst_kidx", bus.o_key_idx, 10);
        chk("mid_rst_pt", bus.o_plaintext, 0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", bus.o_out_valid, 0);
        end
        run_block(CT_C1, PT_C1, 0);

        for (int n = 0; n < 6; n++) begin
            key_expand(rand128());
            p_rnd = rand128();
            run_block(encrypt(p_rnd), p_rnd, int'($urandom_range(0, 3)));
        end

`ifdef AES_INV_STATUS_EN
        force dut.r_blk_count = 16'hFFFF;
        #1;
        release dut.r_blk_count;
        chk("blk_count_preload", blk_count, 16'hFFFF);
        key_expand(KEY_C1);
        run_block(CT_C1, PT_C1, 0);
        chk("blk_count_wrap", blk_count, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
